btb_sa: RTL

Parametrised set-associative branch target buffer for the fetch stage, superseding the direct-mapped BTB. Each cycle it returns predicted next-PCs for the two fetch slots, PC and PC+4. It takes up to two target corrections per cycle from the two ALUs and allocates misses into a pseudo-LRU victim way. Valid bits, a flush input, fall-through prediction on miss and a replacement policy are all new relative to the direct-mapped design.

---
 rtl/btb_pkg.sv | 20 ++
 rtl/btb_plru.sv | 45 ++++
 rtl/btb_sa.sv | 108 ++++++++++
 3 files changed

// File: rtl/btb_pkg.sv
// btb_pkg: shared types and PC field helpers for the set-associative BTB
package btb_pkg;
   localparam int MAX_TAG_W = 62;
   typedef struct packed {
      logic                 valid;
      logic [MAX_TAG_W-1:0] tag;
      logic [61:0]          target;
   } btb_entry_t;
   function automatic int clog2(input int n);
      int r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
   function automatic logic [63:0] get_idx(input logic [63:0] pc, input int idx_w);
      return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
   endfunction
   function automatic logic [63:0] get_tag(input logic [63:0] pc, input int idx_w, input int tag_w);
      return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
   endfunction
endpackage

// File: rtl/btb_plru.sv
// btb_plru: tree-PLRU victim choice (invalid ways first) and MRU update for one set
module btb_plru
   import btb_pkg::*;
#(
   parameter int WAYS = 2,
   parameter int WW = (WAYS > 1) ? clog2(WAYS) : 1,
   parameter int PW = (WAYS > 1) ? WAYS - 1 : 1
) (
   input  logic [PW-1:0]   plru,
   input  logic [WAYS-1:0] valid,
   input  logic [WW-1:0]   acc_way,
   output logic [WW-1:0]   victim,
   output logic [PW-1:0]   nxt
);
   logic [WW-1:0] tree, first;
   logic          any_inv;
   // Lowest-numbered invalid way takes priority over the tree choice
   always_comb begin
      first = '0;
      any_inv = 1'b0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid[w]) begin
            first = WW'(w);
            any_inv = 1'b1;
         end
      end
   end
   if (WAYS == 4) begin : g4
      // Each bit points at the half to evict; accessing a way points the path away from it
      always_comb begin
         tree = plru[0] ? {1'b1, plru[2]} : {1'b0, plru[1]};
         nxt = plru;
         nxt[0] = ~acc_way[1];
         if (acc_way[1]) nxt[2] = ~acc_way[0];
         else nxt[1] = ~acc_way[0];
      end
   end else if (WAYS == 2) begin : g2
      assign tree = WW'(plru[0]);
      assign nxt = PW'(~acc_way[0]);
   end else begin : g1
      assign tree = '0;
      assign nxt = plru;
   end
   assign victim = any_inv ? first : tree;
endmodule

// File: rtl/btb_sa.sv
// btb_sa: set-associative BTB with two fetch lookups, two ALU corrections and tree-PLRU replacement
module btb_sa
   import btb_pkg::*;
#(
   parameter int NUM_SETS = 256,
   parameter int WAYS = 2,
   parameter int TAG_W = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_valid,
   input  logic [63:0] if_pc,
   input  logic        btb_flush,
   input  logic        alu_0_wr,
   input  logic [63:0] alu_0_pc,
   input  logic [63:0] alu_0_correct_npc,
   input  logic        alu_1_wr,
   input  logic [63:0] alu_1_pc,
   input  logic [63:0] alu_1_correct_npc,
   output logic        if_hit0,
   output logic        if_hit1,
   output logic [63:0] if_pred_addr0,
   output logic [63:0] if_pred_addr1
);
   localparam int IDX_W = clog2(NUM_SETS);
   localparam int WW = (WAYS > 1) ? clog2(WAYS) : 1;
   localparam int PW = (WAYS > 1) ? WAYS - 1 : 1;
   btb_entry_t      ent [NUM_SETS][WAYS];
   logic [PW-1:0]   plru [NUM_SETS];
   logic [63:0]     pc [4];
   logic [IDX_W-1:0] idx [4];
   logic [TAG_W-1:0] tag [4];
   logic [WAYS-1:0] vld [4];
   logic [WW-1:0]   hw [4];
   logic            hit [4];
   logic            same, same_tag, keep1, e0, e1, e2, e3;
   logic [WW-1:0]   w2, w3, v2, v3, unused_vic0, unused_vic1;
   logic [WAYS-1:0] vl3;
   logic [PW-1:0]   p0i, p0o, p1i, p1o, p2i, p2o, p3i, p3o;
   logic            unused_npc_lsb;
   // Tag lookup for the four access ports: fetch slot 0, slot 1, alu_0, alu_1
   always_comb begin
      pc[0] = if_pc;
      pc[1] = if_pc + 64'd4;
      pc[2] = alu_0_pc;
      pc[3] = alu_1_pc;
      for (int p = 0; p < 4; p++) begin
         idx[p] = IDX_W'(get_idx(pc[p], IDX_W));
         tag[p] = TAG_W'(get_tag(pc[p], IDX_W, TAG_W));
         vld[p] = '0;
         hw[p] = '0;
         hit[p] = 1'b0;
         for (int w = 0; w < WAYS; w++) begin
            vld[p][w] = ent[idx[p]][w].valid;
            if (ent[idx[p]][w].valid && ent[idx[p]][w].tag == MAX_TAG_W'(tag[p])) begin
               hw[p] = WW'(w);
               hit[p] = 1'b1;
            end
         end
      end
   end
   assign same = alu_0_wr && idx[2] == idx[3];
   assign same_tag = same && tag[2] == tag[3];
   assign e0 = if_valid && hit[0];
   assign e1 = if_valid && hit[1];
   assign e2 = alu_0_wr;
   assign e3 = alu_1_wr && (WAYS > 1 || !same || same_tag);
   assign w2 = hit[2] ? hw[2] : v2;
   // alu_1 sees the set as alu_0 leaves it: its old hit is lost if alu_0 replaced that way
   assign keep1 = hit[3] && !(same && hw[3] == w2);
   assign w3 = same_tag ? w2 : keep1 ? hw[3] : v3;
   assign vl3 = vld[3] | (WAYS'(same) << w2);
   assign p0i = plru[idx[0]];
   assign p1i = (e0 && idx[0] == idx[1]) ? p0o : plru[idx[1]];
   assign p2i = (e1 && idx[1] == idx[2]) ? p1o : (e0 && idx[0] == idx[2]) ? p0o : plru[idx[2]];
   assign p3i = (e2 && idx[2] == idx[3]) ? p2o : (e1 && idx[1] == idx[3]) ? p1o :
                (e0 && idx[0] == idx[3]) ? p0o : plru[idx[3]];
   assign unused_npc_lsb = ^{alu_0_correct_npc[1:0], alu_1_correct_npc[1:0]};
   btb_plru #(.WAYS(WAYS)) u_plru0 (.plru(p0i), .valid(vld[0]), .acc_way(hw[0]), .victim(unused_vic0), .nxt(p0o));
   btb_plru #(.WAYS(WAYS)) u_plru1 (.plru(p1i), .valid(vld[1]), .acc_way(hw[1]), .victim(unused_vic1), .nxt(p1o));
   btb_plru #(.WAYS(WAYS)) u_plru2 (.plru(p2i), .valid(vld[2]), .acc_way(w2), .victim(v2), .nxt(p2o));
   btb_plru #(.WAYS(WAYS)) u_plru3 (.plru(p3i), .valid(vl3), .acc_way(w3), .victim(v3), .nxt(p3o));
   // State update in access order; later writes to the same location win, flush discards all writes
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            plru[s] <= '0;
            for (int w = 0; w < WAYS; w++) ent[s][w] <= '0;
         end
      end else if (btb_flush) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            plru[s] <= '0;
            for (int w = 0; w < WAYS; w++) ent[s][w] <= '0;
         end
      end else begin
         if (e0) plru[idx[0]] <= p0o;
         if (e1) plru[idx[1]] <= p1o;
         if (e2) plru[idx[2]] <= p2o;
         if (e3) plru[idx[3]] <= p3o;
         if (e2) ent[idx[2]][w2] <= {1'b1, MAX_TAG_W'(tag[2]), alu_0_correct_npc[63:2]};
         if (e3) ent[idx[3]][w3] <= {1'b1, MAX_TAG_W'(tag[3]), alu_1_correct_npc[63:2]};
      end
   end
   assign if_hit0 = hit[0];
   assign if_hit1 = hit[1];
   assign if_pred_addr0 = hit[0] ? {ent[idx[0]][hw[0]].target, 2'b00} : pc[1];
   assign if_pred_addr1 = hit[1] ? {ent[idx[1]][hw[1]].target, 2'b00} : if_pc + 64'd8;
endmodule
